// File: rtl/qspi_icache.sv
// rtl/qspi_icache.sv - direct-mapped read-only instruction cache in front of the QSPI controller
// Misses fetch a whole line as nibbles on wstrobe_i; hits answer one cycle after the request.
module qspi_icache #(
  parameter int LINE_LENGTH = 4,
  parameter int PA          = 24,
  parameter int NLINES      = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ifetch_req,
  input  logic [PA-1:1]                      ifetch_addr,
  input  logic [1:0]                         ifetch_mem,
  output logic                               ifetch_ack,
  output logic [15:0]                        ifetch_data,
  input  logic                               flush,
  output logic                               qspi_req,
  output logic                               qspi_i_d,
  output logic                               qspi_write,
  output logic [1:0]                         qspi_mem,
  output logic [PA-$clog2(LINE_LENGTH)-1:0]  qspi_paddr,
  input  logic                               wstrobe_i,
  input  logic [3:0]                         uio_in
);

  localparam int LW = $clog2(LINE_LENGTH);
  localparam int IW = $clog2(NLINES);
  localparam int TW = PA - LW - IW + 2;
  localparam int LB = 8 * LINE_LENGTH;
  localparam int CW = $clog2(2 * LINE_LENGTH);

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t           state_q;
  logic [LB-1:0]    line_q [NLINES];
  logic [TW-1:0]    tags_q [NLINES];
  logic [NLINES-1:0] valid_q;
  logic [LB-1:0]    fill_q, fill_d;
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    fidx_q;
  logic [TW-1:0]    ftag_q;
  logic [LW-1:0]    foff_q;
  logic             flushed_q;

  logic [PA-1:0]    byte_addr;
  logic [LW-1:0]    off_d;
  logic [IW-1:0]    idx_d;
  logic [TW-1:0]    tag_d;
  logic             hit_d;
  logic             last_d;
  logic [15:0]      hit_word;
  logic [15:0]      fill_word;

  assign qspi_i_d   = 1'b1;
  assign qspi_write = 1'b0;

  assign byte_addr = {ifetch_addr, 1'b0};
  assign off_d     = byte_addr[LW-1:0] >> 1;
  assign idx_d     = byte_addr[LW+IW-1:LW];
  assign tag_d     = {ifetch_mem, byte_addr[PA-1:LW+IW]};
  assign hit_d     = valid_q[idx_d] && (tags_q[idx_d] == tag_d);
  assign last_d    = wstrobe_i && (cnt_q == CW'(2 * LINE_LENGTH - 1));
  assign hit_word  = 16'(line_q[idx_d] >> {off_d, 4'b0000});
  assign fill_word = 16'(fill_q >> {foff_q, 4'b0000});

  // Nibble k lands in byte k>>1; the first nibble of each byte is its high half.
  always_comb begin
    fill_d = fill_q;
    fill_d[{cnt_q[CW-1:1], ~cnt_q[0], 2'b00} +: 4] = uio_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ifetch_ack  <= 1'b0;
      ifetch_data <= '0;
      qspi_req    <= 1'b0;
      qspi_mem    <= '0;
      qspi_paddr  <= '0;
      cnt_q       <= '0;
      valid_q     <= '0;
      flushed_q   <= 1'b0;
      fidx_q      <= '0;
      ftag_q      <= '0;
      foff_q      <= '0;
    end else begin
      ifetch_ack <= 1'b0;
      if (flush) valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (ifetch_req && !ifetch_ack) begin
            if (hit_d) begin
              ifetch_ack  <= 1'b1;
              ifetch_data <= hit_word;
            end else begin
              qspi_req   <= 1'b1;
              qspi_paddr <= byte_addr[PA-1:LW];
              qspi_mem   <= ifetch_mem;
              cnt_q      <= '0;
              fidx_q     <= idx_d;
              ftag_q     <= tag_d;
              foff_q     <= off_d;
              flushed_q  <= 1'b0;
              state_q    <= FILL;
            end
          end
        end
        FILL: begin
          if (flush) flushed_q <= 1'b1;
          if (wstrobe_i) begin
            cnt_q <= cnt_q + CW'(1);
            if (last_d) begin
              qspi_req <= 1'b0;
              // A flush seen at any point of the fill leaves the line invalid.
              if (!flush && !flushed_q) valid_q[fidx_q] <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        RESP: begin
          ifetch_ack  <= 1'b1;
          ifetch_data <= fill_word;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == FILL && wstrobe_i) begin
      fill_q <= fill_d;
      if (last_d) begin
        line_q[fidx_q] <= fill_d;
        tags_q[fidx_q] <= ftag_q;
      end
    end
  end

endmodule

// File: tb/tb_qspi_icache.sv
// tb/tb_qspi_icache.sv - bench for qspi_icache against a transparent-flash residency model
// Expected data comes from a lazily filled flash image; hit/miss from a tag/valid table.
module tb_qspi_icache;

  logic        clk = 1'b0;
  logic        reset, ifetch_req, flush, wstrobe_i;
  logic [23:1] ifetch_addr;
  logic [1:0]  ifetch_mem;
  logic [3:0]  uio_in;
  logic        ifetch_ack, qspi_req, qspi_i_d, qspi_write;
  logic [15:0] ifetch_data;
  logic [1:0]  qspi_mem;
  logic [21:0] qspi_paddr;

  int checks = 0;
  int errors = 0;

  bit          vm [8];
  logic [20:0] tm [8];
  logic [7:0]  flash [logic [25:0]];

  qspi_icache dut (
    .clk(clk), .reset(reset), .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr),
    .ifetch_mem(ifetch_mem), .ifetch_ack(ifetch_ack), .ifetch_data(ifetch_data),
    .flush(flush), .qspi_req(qspi_req), .qspi_i_d(qspi_i_d), .qspi_write(qspi_write),
    .qspi_mem(qspi_mem), .qspi_paddr(qspi_paddr), .wstrobe_i(wstrobe_i), .uio_in(uio_in)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] fbyte(input logic [1:0] m, input logic [23:0] a);
    logic [25:0] key = {m, a};
    if (!flash.exists(key)) flash[key] = 8'($urandom);
    return flash[key];
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) vm[i] = 1'b0;
  endtask

  task automatic fetch(input logic [23:0] ba, input logic [1:0] m, input int flush_at,
                       input bit flush_lookup, input int reset_at, input int max_gap);
    int          idx = int'(ba[4:2]);
    logic [20:0] tg = {m, ba[23:5]};
    bit          exp_hit = vm[idx] && (tm[idx] == tg);
    logic [15:0] exp_data = {fbyte(m, ba | 24'd1), fbyte(m, ba & ~24'd1)};
    logic [23:0] base = ba & ~24'd3;
    logic [7:0]  b;
    bit          fl = 1'b0;
    int          n;
    ifetch_req  = 1'b1;
    ifetch_addr = ba[23:1];
    ifetch_mem  = m;
    flush       = flush_lookup;
    @(negedge clk);
    flush = 1'b0;
    if (flush_lookup) clear_model();
    if (exp_hit) begin
      chk("hit_ack", ifetch_ack, 1);
      chk("hit_data", ifetch_data, exp_data);
      chk("hit_no_qspi", qspi_req, 0);
      ifetch_req = 1'b0;
      @(negedge clk);
      chk("hit_ack_pulse", ifetch_ack, 0);
      return;
    end
    chk("miss_req", qspi_req, 1);
    chk("miss_paddr", qspi_paddr, base[23:2]);
    chk("miss_mem", qspi_mem, m);
    chk("miss_noack", ifetch_ack, 0);
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(0, max_gap);
      repeat (n) begin
        wstrobe_i = 1'b0;
        uio_in    = 4'($urandom);
        @(negedge clk);
      end
      if (k == reset_at) begin
        reset      = 1'b1;
        ifetch_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_fill_req", qspi_req, 0);
        chk("rst_fill_ack", ifetch_ack, 0);
        clear_model();
        return;
      end
      b         = fbyte(m, base + 24'(k / 2));
      wstrobe_i = 1'b1;
      uio_in    = (k % 2 == 1) ? b[3:0] : b[7:4];
      flush     = (k == flush_at);
      if (k == flush_at) fl = 1'b1;
      @(negedge clk);
      wstrobe_i = 1'b0;
      flush     = 1'b0;
      if (k < 7) begin
        chk("fill_req_held", qspi_req, 1);
        chk("fill_paddr_stable", qspi_paddr, base[23:2]);
      end
    end
    chk("req_fall", qspi_req, 0);
    n = 0;
    while (!ifetch_ack && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("fill_ack", ifetch_ack, 1);
    chk("fill_data", ifetch_data, exp_data);
    ifetch_req = 1'b0;
    @(negedge clk);
    chk("fill_ack_pulse", ifetch_ack, 0);
    if (fl) clear_model();
    else begin
      vm[idx] = 1'b1;
      tm[idx] = tg;
    end
  endtask

  initial begin
    logic [23:0] ba;
    logic [1:0]  m;
    int          fa;
    reset = 1'b1; ifetch_req = 1'b0; ifetch_addr = '0; ifetch_mem = '0;
    flush = 1'b0; wstrobe_i = 1'b0; uio_in = '0;
    clear_model();
    flash[{2'd0, 24'h10}] = 8'h12;
    flash[{2'd0, 24'h11}] = 8'h34;
    flash[{2'd0, 24'h12}] = 8'h56;
    flash[{2'd0, 24'h13}] = 8'h78;
    repeat (2) @(negedge clk);
    chk("rst_ack", ifetch_ack, 0);
    chk("rst_qspi_req", qspi_req, 0);
    chk("rst_paddr", qspi_paddr, 0);
    chk("rst_mem", qspi_mem, 0);
    chk("rst_data", ifetch_data, 0);
    chk("i_d_const", qspi_i_d, 1);
    chk("write_const", qspi_write, 0);
    reset = 1'b0;
    @(negedge clk);

    fetch(24'h10, 2'd0, -1, 1'b0, -1, 0);
    chk("cold_data_const", ifetch_data, 16'h3412);
    fetch(24'h12, 2'd0, -1, 1'b0, -1, 0);
    chk("hit_data_const", ifetch_data, 16'h7856);
    fetch(24'h30, 2'd0, -1, 1'b0, -1, 1);
    fetch(24'h10, 2'd0, -1, 1'b0, -1, 1);
    fetch(24'h10, 2'd2, -1, 1'b0, -1, 1);
    fetch(24'h40, 2'd0, 3, 1'b0, -1, 0);
    fetch(24'h40, 2'd0, -1, 1'b0, -1, 0);
    fetch(24'h50, 2'd0, 7, 1'b0, -1, 0);
    fetch(24'h52, 2'd0, -1, 1'b0, -1, 0);
    fetch(24'h50, 2'd0, -1, 1'b1, -1, 0);
    fetch(24'h50, 2'd0, -1, 1'b0, -1, 0);
    fetch(24'h60, 2'd1, -1, 1'b0, 3, 0);
    fetch(24'h60, 2'd1, -1, 1'b0, -1, 0);
    fetch(24'h62, 2'd1, -1, 1'b0, -1, 0);

    for (int i = 0; i < 40; i++) begin
      ba = 24'(2 * $urandom_range(0, 47));
      m  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
      fetch(ba, m, fa, 1'b0, -1, 2);
      repeat ($urandom_range(0, 3)) begin
        wstrobe_i = 1'($urandom);
        uio_in    = 4'($urandom);
        @(negedge clk);
      end
      wstrobe_i = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
